// File: rtl/clock_pkg.sv
// Shared definitions for the clock datapath and its set-mode controller.
package clock_pkg;

  localparam int CLK_WIDTH = 32;

  // Encoding is exported directly on the mode output.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HRS = 2'd1,
    SET_MIN = 2'd2,
    COMMIT  = 2'd3
  } clk_state_e;

endpackage

// File: rtl/clock_tick_gen.sv
// Prescaler producing a registered one-cycle enable every TICK_DIV cycles.
module clock_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_en
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;
  logic          r_en;

  // A clear parks the count at 0 and suppresses any pulse due on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_en  <= 1'b0;
    end else begin
      r_en  <= (r_cnt == LAST);
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    end
  end

  assign o_en = r_en;

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the h:m:s clock: tick enable in RUN, button-driven
// shadow editing of hours then minutes, committed by a one-cycle load strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int WIDTH    = CLK_WIDTH,
  parameter int TICK_DIV = 100000000,
  parameter int TIMEOUT  = 1000000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [WIDTH-1:0] count_max,
  input  logic [WIDTH-1:0] count_max_hrs,
  input  logic [WIDTH-1:0] count_hrs,
  input  logic [WIDTH-1:0] count_min,
  output logic             en,
  output logic             load,
  output logic [WIDTH-1:0] load_hrs,
  output logic [WIDTH-1:0] load_min,
  output logic [WIDTH-1:0] load_sec,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] shadow_hrs,
  output logic [WIDTH-1:0] shadow_min
);

  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  clk_state_e     r_state;
  logic [IW-1:0]  r_idle;
  logic [WIDTH-1:0] r_shadow_hrs, r_shadow_min;
  logic [WIDTH-1:0] r_load_hrs, r_load_min, r_load_sec;
  logic           r_load;
  logic           w_tick_clr;
  logic           w_en;

  // >= rather than == so a shadow left above a lowered limit still wraps.
  function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] lim);
    return (v >= lim) ? '0 : v + WIDTH'(1);
  endfunction

  // Prescaler is held at 0 outside RUN, so every return to RUN restarts it.
  assign w_tick_clr = (r_state != RUN) || btn_mode;

  clock_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_tick_clr),
    .o_en  (w_en)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_idle       <= '0;
      r_shadow_hrs <= '0;
      r_shadow_min <= '0;
      r_load       <= 1'b0;
      r_load_hrs   <= '0;
      r_load_min   <= '0;
      r_load_sec   <= '0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        RUN: begin
          if (btn_mode) begin
            r_shadow_hrs <= count_hrs;
            r_shadow_min <= count_min;
            r_idle       <= '0;
            r_state      <= SET_HRS;
          end
        end
        SET_HRS: begin
          if (btn_mode) begin
            r_idle  <= '0;
            r_state <= SET_MIN;
          end else if (btn_inc) begin
            r_idle       <= '0;
            r_shadow_hrs <= wrap_inc(r_shadow_hrs, count_max_hrs);
          end else if (r_idle == IDLE_LAST) begin
            r_idle  <= '0;
            r_state <= RUN;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        SET_MIN: begin
          if (btn_mode) begin
            r_idle     <= '0;
            r_state    <= COMMIT;
            r_load     <= 1'b1;
            r_load_hrs <= r_shadow_hrs;
            r_load_min <= r_shadow_min;
            r_load_sec <= '0;
          end else if (btn_inc) begin
            r_idle       <= '0;
            r_shadow_min <= wrap_inc(r_shadow_min, count_max);
          end else if (r_idle == IDLE_LAST) begin
            r_idle  <= '0;
            r_state <= RUN;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        COMMIT:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  assign en         = w_en;
  assign load       = r_load;
  assign load_hrs   = r_load_hrs;
  assign load_min   = r_load_min;
  assign load_sec   = r_load_sec;
  assign mode       = r_state;
  assign shadow_hrs = r_shadow_hrs;
  assign shadow_min = r_shadow_min;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed table, corner sequences, randomized run
// against a rule-level model of the set-mode controller.
module tb_clock_set_ctrl;

  localparam int W   = 32;
  localparam int TD  = 4;
  localparam int TO  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_mode, btn_inc;
  logic [W-1:0]  count_max, count_max_hrs, count_hrs, count_min;
  logic          en, load;
  logic [W-1:0]  load_hrs, load_min, load_sec, shadow_hrs, shadow_min;
  logic [1:0]    mode;

  always #5 clk = ~clk;

  clock_set_ctrl #(.WIDTH(W), .TICK_DIV(TD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .count_max(count_max), .count_max_hrs(count_max_hrs),
    .count_hrs(count_hrs), .count_min(count_min),
    .en(en), .load(load), .load_hrs(load_hrs), .load_min(load_min),
    .load_sec(load_sec), .mode(mode), .shadow_hrs(shadow_hrs),
    .shadow_min(shadow_min)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Model: mode, shadows, last committed values, cycles since RUN (re)started
  // with a fresh prescaler, and consecutive quiet cycles while editing.
  int           m_mode;
  logic [W-1:0] m_sh, m_sm, m_lh, m_lm;
  bit           m_en, m_load;
  int           m_t, m_quiet;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_sh = '0; m_sm = '0; m_lh = '0; m_lm = '0;
    m_en = 0; m_load = 0; m_t = 0; m_quiet = 0;
  endtask

  task automatic model_step(input bit bm, input bit bi);
    m_en = 0; m_load = 0;
    case (m_mode)
      0: if (bm) begin
           m_sh = count_hrs; m_sm = count_min; m_mode = 1; m_quiet = 0;
         end else begin
           m_t++;
           m_en = (m_t % TD == 0);
         end
      1, 2: if (bm) begin
           if (m_mode == 2) begin m_load = 1; m_lh = m_sh; m_lm = m_sm; end
           m_mode++; m_quiet = 0;
         end else if (bi) begin
           if (m_mode == 1) m_sh = (m_sh >= count_max_hrs) ? '0 : m_sh + 32'd1;
           else             m_sm = (m_sm >= count_max)     ? '0 : m_sm + 32'd1;
           m_quiet = 0;
         end else begin
           m_quiet++;
           if (m_quiet == TO) begin m_mode = 0; m_t = 0; m_quiet = 0; end
         end
      default: begin m_mode = 0; m_t = 0; end
    endcase
  endtask

  task automatic compare_all();
    chk("mode", {30'd0, mode}, 32'(m_mode));
    chk("en", {31'd0, en}, {31'd0, m_en});
    chk("load", {31'd0, load}, {31'd0, m_load});
    chk("shadow_hrs", shadow_hrs, m_sh);
    chk("shadow_min", shadow_min, m_sm);
    chk("load_hrs", load_hrs, m_lh);
    chk("load_min", load_min, m_lm);
    chk("load_sec", load_sec, 32'd0);
    chk("en_load_excl", {31'd0, en & load}, 32'd0);
  endtask

  // Called at a negedge: drive buttons, advance model at posedge, check at negedge.
  task automatic cyc(input bit bm, input bit bi);
    btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_step(bm, bi);
    @(negedge clk);
    btn_mode = 0; btn_inc = 0;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    compare_all();
    reset = 1'b1;
  endtask

  typedef struct {
    bit           bm, bi;
    int           exp_mode;
    logic [W-1:0] exp_sh, exp_sm;
    bit           exp_load;
  } vec_t;

  vec_t vecs[10];
  int   pulses, loads;

  initial begin
    reset = 1'b0; btn_mode = 0; btn_inc = 0;
    count_max = 59; count_max_hrs = 23; count_hrs = 22; count_min = 58;

    vecs[0] = '{1, 0, 1, 22, 58, 0};
    vecs[1] = '{0, 1, 1, 23, 58, 0};
    vecs[2] = '{0, 1, 1,  0, 58, 0};
    vecs[3] = '{0, 1, 1,  1, 58, 0};
    vecs[4] = '{1, 0, 2,  1, 58, 0};
    vecs[5] = '{0, 1, 2,  1, 59, 0};
    vecs[6] = '{0, 1, 2,  1,  0, 0};
    vecs[7] = '{0, 1, 2,  1,  1, 0};
    vecs[8] = '{1, 0, 3,  1,  1, 1};
    vecs[9] = '{0, 0, 0,  1,  1, 0};

    @(negedge clk);
    do_reset();

    // Tick generation
    pulses = 0; loads = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(0, 0);
      pulses += int'(en);
      loads  += int'(load);
    end
    chk("tick_pulses", 32'(pulses), 32'd10);
    chk("tick_loads", 32'(loads), 32'd0);

    // Full set sequence
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].bm, vecs[i].bi);
      chk("tbl_mode", {30'd0, mode}, 32'(vecs[i].exp_mode));
      chk("tbl_shadow_hrs", shadow_hrs, vecs[i].exp_sh);
      chk("tbl_shadow_min", shadow_min, vecs[i].exp_sm);
      chk("tbl_load", {31'd0, load}, {31'd0, vecs[i].exp_load});
      if (vecs[i].exp_load) begin
        chk("tbl_load_hrs", load_hrs, 32'd1);
        chk("tbl_load_min", load_min, 32'd1);
        chk("tbl_load_sec", load_sec, 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk("commit_en_quiet", {31'd0, en}, 32'd0);
    end
    cyc(0, 0);
    chk("commit_first_en", {31'd0, en}, 32'd1);

    // Simultaneous buttons in SET_HRS
    cyc(1, 0);
    cyc(1, 1);
    chk("simul_mode", {30'd0, mode}, 32'd2);
    chk("simul_shadow_hrs", shadow_hrs, 32'd22);
    cyc(1, 0);
    cyc(0, 0);

    // Idle timeout
    cyc(1, 0);
    loads = 0;
    for (int i = 1; i <= TO; i++) begin
      cyc(0, 0);
      loads += int'(load);
      if (i < TO) chk("timeout_hold", {30'd0, mode}, 32'd1);
    end
    chk("timeout_run", {30'd0, mode}, 32'd0);
    chk("timeout_no_load", 32'(loads), 32'd0);
    chk("timeout_shadow_kept", shadow_hrs, 32'd22);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk("timeout_en_quiet", {31'd0, en}, 32'd0);
    end
    cyc(0, 0);
    chk("timeout_first_en", {31'd0, en}, 32'd1);

    // Limit clamp
    cyc(1, 0);
    cyc(1, 0);
    cyc(0, 1);
    chk("clamp_pre", shadow_min, 32'd59);
    count_max = 30;
    cyc(0, 1);
    chk("clamp_wrap", shadow_min, 32'd0);
    count_max = 59;
    cyc(1, 0);
    cyc(0, 0);

    // Async reset mid-edit
    cyc(1, 0);
    cyc(0, 1);
    cyc(1, 0);
    cyc(0, 1);
    #2 reset = 1'b0;
    #1;
    chk("areset_mode", {30'd0, mode}, 32'd0);
    chk("areset_en", {31'd0, en}, 32'd0);
    chk("areset_load", {31'd0, load}, 32'd0);
    chk("areset_shadow_hrs", shadow_hrs, 32'd0);
    chk("areset_shadow_min", shadow_min, 32'd0);
    model_reset();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
    loads = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0);
      loads += int'(load);
    end
    chk("areset_no_load", 32'(loads), 32'd0);

    // Randomized run against the model
    begin
      int dm, di;
      dm = 4; di = 3;
      for (int i = 0; i < 3000; i++) begin
        if (i % 200 == 0) begin
          dm = int'($urandom_range(2, 40));
          di = int'($urandom_range(1, 30));
        end
        if ($urandom_range(0, 49) == 0) begin
          count_max     = $urandom_range(0, 70);
          count_max_hrs = $urandom_range(0, 30);
        end
        if ($urandom_range(0, 9) == 0) begin
          count_hrs = $urandom_range(0, 30);
          count_min = $urandom_range(0, 70);
        end
        cyc($urandom_range(0, dm) == 0, $urandom_range(0, di) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Sequencer and configuration controller for the hours/minutes/seconds clock datapath. It generates the one-cycle count enable from a prescaler in normal run mode. It also provides a button-driven set mode in which the user edits hours, then minutes, in shadow registers. Edits are committed to the clock through a one-cycle load strobe. It sits between debounced user buttons and the clock counter block.

Parameters:
WIDTH, 32, width of all time values and limits (matches clock datapath)
TICK_DIV, 100000000, clk cycles per en pulse (>=2)
TIMEOUT, 1000000000, idle clk cycles in set mode before automatic abort (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
btn_mode  input  1  debounced single-cycle pulse: enter set mode / advance field
btn_inc  input  1  debounced single-cycle pulse: increment field being edited
count_max  input  WIDTH  minutes/seconds terminal value (e.g. 59)
count_max_hrs  input  WIDTH  hours terminal value (e.g. 23)
count_hrs  input  WIDTH  current hours from clock
count_min  input  WIDTH  current minutes from clock
en  output  1  count enable to clock, one-cycle pulse
load  output  1  one-cycle load strobe to clock
load_hrs  output  WIDTH  hours value accompanying load
load_min  output  WIDTH  minutes value accompanying load
load_sec  output  WIDTH  seconds value accompanying load, always 0
mode  output  2  0=RUN, 1=SET_HRS, 2=SET_MIN, 3=COMMIT
shadow_hrs  output  WIDTH  hours being edited (for display)
shadow_min  output  WIDTH  minutes being edited (for display)

Behaviour:
- Reset (reset=0, async): state RUN; prescaler, idle counter, shadow_hrs, shadow_min, load_hrs, load_min, load_sec all 0; en=0, load=0, mode=0.
- All outputs are registered.
- RUN state:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - en=1 for exactly the cycle after the prescaler reaches TICK_DIV-1. Period is TICK_DIV cycles; the first en occurs TICK_DIV cycles after reset release.
  - btn_mode: shadow_hrs<=count_hrs, shadow_min<=count_min, prescaler<=0, idle<=0, go to SET_HRS. en is forced 0 from the next cycle.
- SET_HRS:
  - btn_inc: shadow_hrs <= (shadow_hrs>=count_max_hrs) ? 0 : shadow_hrs+1.
  - btn_mode: go to SET_MIN.
- SET_MIN:
  - btn_inc: shadow_min <= (shadow_min>=count_max) ? 0 : shadow_min+1.
  - btn_mode: go to COMMIT.
- COMMIT: lasts exactly one cycle.
  - load=1, load_hrs=shadow_hrs, load_min=shadow_min, load_sec=0, all valid in the same cycle.
  - Next state is RUN with prescaler=0. The first en follows TICK_DIV cycles later. Buttons are ignored in COMMIT.
- Idle timeout:
  - In SET_HRS and SET_MIN, the idle counter increments every cycle and clears on any button pulse.
  - At TIMEOUT-1 the FSM returns to RUN without a load; shadows are retained and the prescaler restarts at 0.
- Simultaneous btn_mode and btn_inc: mode wins; the inc is dropped.
- The >= compares guard against shadows above the limit (e.g. a limit changed mid-edit): the next inc wraps to 0.
- All arithmetic is unsigned WIDTH bits; no overflow is possible given the wrap rules.
- en and load are never high in the same cycle; en is never high outside RUN.
- Reset asserted mid-edit: immediate return to RUN; no load is issued.

Decomposition:
- Shared package clock_pkg:
  - State enum constants RUN/SET_HRS/SET_MIN/COMMIT (2-bit), matching mode encoding.
  - Default WIDTH.
- One natural sub-module: clock_tick_gen (prescaler with sync clear, en output), reused by other timed blocks.
- The FSM, shadows and timeout live in the top.

Test Plan:
- Tick generation: TICK_DIV=4, hold in RUN 40 cycles -> en high exactly every 4th cycle (10 pulses), load=0 throughout.
- Full set sequence: count_hrs=22, count_min=58.
  - Stimulus: btn_mode, 3×btn_inc, btn_mode, 3×btn_inc, btn_mode.
  - Required: hours 22->23->0->1, minutes 58->59->0->1.
  - COMMIT cycle: load=1, load_hrs=1, load_min=1, load_sec=0, mode=3.
  - Then mode=0 and first en 4 cycles later.
- Simultaneous buttons: in SET_HRS, btn_mode and btn_inc in the same cycle -> mode=2, shadow_hrs unchanged.
- Timeout: TIMEOUT=16, enter SET_HRS, no buttons -> RUN after 16 cycles, no load pulse, en resumes 4 cycles after that.
- Async reset mid-edit: in SET_MIN, pull reset low between clock edges -> mode=0, en=0, load=0, shadows=0 immediately (before the next clk edge); no load after release.
- Limit clamp: in SET_MIN with shadow_min=59, drive count_max=30 then btn_inc -> shadow_min=0.
